// File: rtl/usr_pkg.sv
// Shared constants and state type for the universal shift register.
// Optional rotate support is selected with the USR_ROTATE_EN macro.
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

endpackage

// File: rtl/usr_step.sv
// Combinational next-value of the register for one step (hold/shift/load).
// With USR_ROTATE_EN defined, rot=1 turns shifts into rotates.
module usr_step
  import usr_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] q,
  input  logic [1:0]   op,
  input  logic [N-1:0] d,
  input  logic         fill,
`ifdef USR_ROTATE_EN
  input  logic         rot,
`endif
  output logic [N-1:0] nxt
);

  logic fill_r;
  logic fill_l;

  // Rotation reuses the bit falling off the opposite end as the fill bit.
`ifdef USR_ROTATE_EN
  assign fill_r = rot ? q[0]   : fill;
  assign fill_l = rot ? q[N-1] : fill;
`else
  assign fill_r = fill;
  assign fill_l = fill;
`endif

  always_comb begin
    nxt = q;
    case (op)
      MODE_SHR:  nxt = {fill_r, q[N-1:1]};
      MODE_SHL:  nxt = {q[N-2:0], fill_l};
      MODE_LOAD: nxt = d;
      default:   nxt = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// N-bit universal register: single-step hold/shift/load plus a multi-cycle
// shift-by-AMT with BUSY/DONE. Macro USR_ROTATE_EN adds the ROT input.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter  int N  = 8,
  localparam int AW = $clog2(N) + 1
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          EN,
  input  logic [1:0]    MODE,
  input  logic [N-1:0]  D,
  input  logic          SIR,
  input  logic          SIL,
  input  logic          START,
  input  logic          DIR,
  input  logic [AW-1:0] AMT,
`ifdef USR_ROTATE_EN
  input  logic          ROT,
`endif
  output logic [N-1:0]  Q,
  output logic          BUSY,
  output logic          DONE
);

  state_t        state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic          dir_l, dir_n;
  logic [N-1:0]  q, q_n;
  logic          done, done_n;

  logic [1:0]    step_op;
  logic          step_fill;
  logic [N-1:0]  step_q;

  // In SHIFT the step unit follows the latched direction, otherwise MODE.
  always_comb begin
    step_op = MODE;
    if (state == ST_SHIFT) begin
      step_op = (dir_l == DIR_L) ? MODE_SHL : MODE_SHR;
    end
  end

  assign step_fill = (step_op == MODE_SHL) ? SIL : SIR;

  usr_step #(.N(N)) u_step (
    .q    (q),
    .op   (step_op),
    .d    (D),
    .fill (step_fill),
`ifdef USR_ROTATE_EN
    .rot  (ROT),
`endif
    .nxt  (step_q)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dir_n   = dir_l;
    q_n     = q;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          dir_n = DIR;
          cnt_n = AMT;
          if (AMT != '0) begin
            state_n = ST_SHIFT;
          end else begin
            done_n = 1'b1;
          end
        end else if (EN) begin
          q_n = step_q;
        end
      end
      ST_SHIFT: begin
        if (EN) begin
          q_n   = step_q;
          cnt_n = cnt - AW'(1);
          if (cnt == AW'(1)) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // CLR wins in every state and silently aborts an in-flight shift.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= ST_IDLE;
      cnt   <= '0;
      dir_l <= DIR_R;
      q     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dir_l <= dir_n;
      q     <= q_n;
      done  <= done_n;
    end
  end

  assign Q    = q;
  assign BUSY = (state == ST_SHIFT);
  assign DONE = done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (N=8): table-driven vectors with a
// scoreboard queue, plus hand sequences for abort and AMT > N.
module tb_univ_shift_reg;

  localparam int N  = 8;
  localparam int AW = $clog2(N) + 1;

  logic          CLK;
  logic          CLR;
  logic          EN;
  logic [1:0]    MODE;
  logic [N-1:0]  D;
  logic          SIR;
  logic          SIL;
  logic          START;
  logic          DIR;
  logic [AW-1:0] AMT;
  logic          ROT;
  logic [N-1:0]  Q;
  logic          BUSY;
  logic          DONE;

  univ_shift_reg #(.N(N)) dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .EN    (EN),
    .MODE  (MODE),
    .D     (D),
    .SIR   (SIR),
    .SIL   (SIL),
    .START (START),
    .DIR   (DIR),
    .AMT   (AMT),
`ifdef USR_ROTATE_EN
    .ROT   (ROT),
`endif
    .Q     (Q),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic          clr;
    logic          en;
    logic [1:0]    mode;
    logic [N-1:0]  d;
    logic          sir;
    logic          sil;
    logic          start;
    logic          dir;
    logic [AW-1:0] amt;
    logic          rot;
    logic [N-1:0]  exp_q;
    logic          exp_busy;
    logic          exp_done;
  } vec_t;

  typedef struct {
    logic [N-1:0] q;
    logic         busy;
    logic         done;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic clr, logic en, logic [1:0] mode, logic [N-1:0] d,
                              logic sir, logic sil, logic start, logic dir,
                              logic [AW-1:0] amt, logic rot,
                              logic [N-1:0] q, logic busy, logic done);
    vec_t v;
    v.clr = clr; v.en = en; v.mode = mode; v.d = d;
    v.sir = sir; v.sil = sil; v.start = start; v.dir = dir;
    v.amt = amt; v.rot = rot;
    v.exp_q = q; v.exp_busy = busy; v.exp_done = done;
    return v;
  endfunction

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard empty: got Q=%h required an entry", tag, Q);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (Q !== e.q) begin
      errors++;
      $display("[TB] FAIL %s Q: got %h required %h", tag, Q, e.q);
    end
    checks++;
    if (BUSY !== e.busy) begin
      errors++;
      $display("[TB] FAIL %s BUSY: got %b required %b", tag, BUSY, e.busy);
    end
    checks++;
    if (DONE !== e.done) begin
      errors++;
      $display("[TB] FAIL %s DONE: got %b required %b", tag, DONE, e.done);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    exp_t e;
    CLR = v.clr; EN = v.en; MODE = v.mode; D = v.d;
    SIR = v.sir; SIL = v.sil; START = v.start; DIR = v.dir;
    AMT = v.amt; ROT = v.rot;
    e.q = v.exp_q; e.busy = v.exp_busy; e.done = v.exp_done;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [N-1:0] model;

    CLR = 1'b1; EN = 1'b0; MODE = 2'b00; D = '0; SIR = 1'b0; SIL = 1'b0;
    START = 1'b0; DIR = 1'b0; AMT = '0; ROT = 1'b0;

    // clr en mode d sir sil start dir amt rot | Q BUSY DONE
    tbl.push_back(mk(1,0,2'b00,8'h00,0,0,0,0,4'd0,0, 8'h00,0,0));
    // CLR beats both load and START
    tbl.push_back(mk(0,1,2'b11,8'hA5,0,0,0,0,4'd0,0, 8'hA5,0,0));
    tbl.push_back(mk(1,1,2'b11,8'hFF,0,0,1,0,4'd3,0, 8'h00,0,0));
    tbl.push_back(mk(0,0,2'b00,8'h00,0,0,0,0,4'd0,0, 8'h00,0,0));
    // single-step ops
    tbl.push_back(mk(0,1,2'b11,8'hB4,0,0,0,0,4'd0,0, 8'hB4,0,0));
    tbl.push_back(mk(0,1,2'b01,8'h00,1,0,0,0,4'd0,0, 8'hDA,0,0));
    tbl.push_back(mk(0,1,2'b10,8'h00,0,0,0,0,4'd0,0, 8'hB4,0,0));
    tbl.push_back(mk(0,0,2'b11,8'hFF,0,0,0,0,4'd0,0, 8'hB4,0,0));
    tbl.push_back(mk(0,1,2'b00,8'hFF,0,0,0,0,4'd0,0, 8'hB4,0,0));
    tbl.push_back(mk(0,1,2'b10,8'h00,0,1,0,0,4'd0,0, 8'h69,0,0));
    // multi-cycle left by 3
    tbl.push_back(mk(0,1,2'b11,8'h81,0,0,0,0,4'd0,0, 8'h81,0,0));
    tbl.push_back(mk(0,1,2'b00,8'h00,0,0,1,1,4'd3,0, 8'h81,1,0));
    tbl.push_back(mk(0,1,2'b00,8'h00,0,0,0,1,4'd0,0, 8'h02,1,0));
    tbl.push_back(mk(0,1,2'b00,8'h00,0,0,0,1,4'd0,0, 8'h04,1,0));
    tbl.push_back(mk(0,1,2'b00,8'h00,0,0,0,1,4'd0,0, 8'h08,0,1));
    tbl.push_back(mk(0,0,2'b00,8'h00,0,0,0,0,4'd0,0, 8'h08,0,0));
    // AMT = 0
    tbl.push_back(mk(0,1,2'b11,8'h3C,0,0,0,0,4'd0,0, 8'h3C,0,0));
    tbl.push_back(mk(0,0,2'b00,8'h00,0,0,1,0,4'd0,0, 8'h3C,0,1));
    tbl.push_back(mk(0,0,2'b00,8'h00,0,0,0,0,4'd0,0, 8'h3C,0,0));
    // right by 3 with stalls, START/MODE/D ignored mid-shift
    tbl.push_back(mk(0,1,2'b11,8'h00,0,0,0,0,4'd0,0, 8'h00,0,0));
    tbl.push_back(mk(0,1,2'b00,8'h00,1,0,1,0,4'd3,0, 8'h00,1,0));
    tbl.push_back(mk(0,1,2'b00,8'h00,1,0,0,0,4'd0,0, 8'h80,1,0));
    tbl.push_back(mk(0,0,2'b11,8'hFF,1,0,1,1,4'd2,0, 8'h80,1,0));
    tbl.push_back(mk(0,0,2'b00,8'h00,1,0,0,0,4'd0,0, 8'h80,1,0));
    tbl.push_back(mk(0,1,2'b11,8'hFF,1,0,1,0,4'd0,0, 8'hC0,1,0));
    tbl.push_back(mk(0,1,2'b00,8'h00,1,0,0,0,4'd0,0, 8'hE0,0,1));
    tbl.push_back(mk(0,0,2'b00,8'h00,1,0,0,0,4'd0,0, 8'hE0,0,0));
`ifdef USR_ROTATE_EN
    tbl.push_back(mk(0,1,2'b11,8'h81,0,0,0,0,4'd0,0, 8'h81,0,0));
    tbl.push_back(mk(0,1,2'b01,8'h00,0,0,0,0,4'd0,1, 8'hC0,0,0));
    tbl.push_back(mk(0,1,2'b00,8'h00,0,0,1,1,4'd4,1, 8'hC0,1,0));
    tbl.push_back(mk(0,1,2'b00,8'h00,0,0,0,1,4'd0,1, 8'h81,1,0));
    tbl.push_back(mk(0,1,2'b00,8'h00,0,0,0,1,4'd0,1, 8'h03,1,0));
    tbl.push_back(mk(0,1,2'b00,8'h00,0,0,0,1,4'd0,1, 8'h06,1,0));
    tbl.push_back(mk(0,1,2'b00,8'h00,0,0,0,1,4'd0,1, 8'h0C,0,1));
`endif

    @(posedge CLK);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i], $sformatf("vec[%0d]", i));
    end

    // CLR mid-shift aborts without a DONE
    applyStimulus(mk(0,1,2'b11,8'h5A,0,0,0,0,4'd0,0, 8'h5A,0,0), "abort_load");
    applyStimulus(mk(0,1,2'b00,8'h00,0,0,1,0,4'd5,0, 8'h5A,1,0), "abort_start");
    applyStimulus(mk(0,1,2'b00,8'h00,0,0,0,0,4'd0,0, 8'h2D,1,0), "abort_shift");
    applyStimulus(mk(1,1,2'b00,8'h00,0,0,0,0,4'd0,0, 8'h00,0,0), "abort_clr");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(0,1,2'b00,8'h00,0,0,0,0,4'd0,0, 8'h00,0,0),
                    $sformatf("abort_after[%0d]", i));
    end

    // AMT > N: ones shifted in from the right, saturating at all-ones
    model = 8'h00;
    applyStimulus(mk(0,1,2'b11,8'h00,0,0,0,0,4'd0,0, model,0,0), "big_load");
    applyStimulus(mk(0,1,2'b00,8'h00,0,1,1,1,4'd9,0, model,1,0), "big_start");
    for (int i = 1; i <= 9; i++) begin
      model = {model[N-2:0], 1'b1};
      applyStimulus(mk(0,1,2'b00,8'h00,0,1,0,1,4'd0,0, model, (i < 9), (i == 9)),
                    $sformatf("big_shift[%0d]", i));
    end
    applyStimulus(mk(0,0,2'b00,8'h00,0,0,0,0,4'd0,0, 8'hFF,0,0), "big_idle");

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
